// File: rtl/sprite_pkg.sv
// Shared constants for the sprite compositor: default geometry, key colour
// and the RGB444 field positions inside a colour word.
package sprite_pkg;

  localparam int DEF_NUM_SPRITES = 4;
  localparam int DEF_SPR_W       = 14;
  localparam int DEF_SPR_H       = 16;
  localparam int DEF_PIX_W       = 10;
  localparam int DEF_COLOR_W     = 12;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_ROM_LAT     = 1;

  // Pink marks transparent sprite pixels
  localparam logic [11:0] DEF_KEY_COLOR = 12'hA0A;

  // RGB444 field slices within a 12-bit colour word
  localparam int RED_HI = 11;
  localparam int RED_LO = 8;
  localparam int GRN_HI = 7;
  localparam int GRN_LO = 4;
  localparam int BLU_HI = 3;
  localparam int BLU_LO = 0;

endpackage

// File: rtl/sprite_hit_test.sv
// Window test and ROM address for one sprite against the current pixel.
module sprite_hit_test
  import sprite_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int SPR_W  = DEF_SPR_W,
  parameter int SPR_H  = DEF_SPR_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [PIX_W-1:0]  hor_pix_i,
  input  logic [PIX_W-1:0]  ver_pix_i,
  input  logic [PIX_W-1:0]  x_i,
  input  logic [PIX_W-1:0]  y_i,
  input  logic              en_i,
  output logic              on_o,
  output logic [ADDR_W-1:0] addr_o
);

  // One extra bit keeps a sprite near the right/bottom edge from wrapping
  // around and matching small counter values.
  logic [PIX_W:0]   x_end, y_end;
  logic             in_x, in_y;
  logic [PIX_W-1:0] dx, dy;

  assign x_end = {1'b0, x_i} + (PIX_W+1)'(SPR_W);
  assign y_end = {1'b0, y_i} + (PIX_W+1)'(SPR_H);

  assign in_x = (hor_pix_i >= x_i) && ({1'b0, hor_pix_i} < x_end);
  assign in_y = (ver_pix_i >= y_i) && ({1'b0, ver_pix_i} < y_end);
  assign on_o = en_i && in_x && in_y;

  // Offsets are bounded by the sprite size, so ADDR_W bits hold them exactly
  assign dx     = hor_pix_i - x_i;
  assign dy     = ver_pix_i - y_i;
  assign addr_o = on_o ? (ADDR_W'(dx) + ADDR_W'(dy) * ADDR_W'(SPR_W)) : '0;

endmodule

// File: rtl/sprite_compositor.sv
// Composites NUM_SPRITES colour-keyed sprites over an external background and
// reports per-frame pixel-accurate collisions of sprite 0 with the others.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = DEF_NUM_SPRITES,
  parameter int SPR_W       = DEF_SPR_W,
  parameter int SPR_H       = DEF_SPR_H,
  parameter int PIX_W       = DEF_PIX_W,
  parameter int COLOR_W     = DEF_COLOR_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int ROM_LAT     = DEF_ROM_LAT,
  parameter logic [COLOR_W-1:0] KEY_COLOR = COLOR_W'(DEF_KEY_COLOR)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           pix_en,
  input  logic [PIX_W-1:0]               hor_pix,
  input  logic [PIX_W-1:0]               ver_pix,
  input  logic                           frame_end,
  input  logic [NUM_SPRITES*PIX_W-1:0]   spr_x,
  input  logic [NUM_SPRITES*PIX_W-1:0]   spr_y,
  input  logic [NUM_SPRITES-1:0]         spr_en,
  output logic [NUM_SPRITES*ADDR_W-1:0]  rom_addr,
  input  logic [NUM_SPRITES*COLOR_W-1:0] rom_data,
  input  logic                           bg_on,
  input  logic [COLOR_W-1:0]             bg_color,
  output logic [COLOR_W-1:0]             color_out,
  output logic                           color_valid,
  output logic [NUM_SPRITES-1:0]         hit_mask,
  output logic                           hit_any
);

  // Address register plus ROM_LAT ROM stages brings flags level with rom_data
  localparam int DLY = 1 + ROM_LAT;

  logic [NUM_SPRITES*PIX_W-1:0]  shadow_x_q, shadow_y_q;
  logic [NUM_SPRITES-1:0]        shadow_en_q;
  logic [NUM_SPRITES-1:0]        on_d;
  logic [NUM_SPRITES*ADDR_W-1:0] addr_d, rom_addr_q;
  logic [NUM_SPRITES-1:0]        on_dly_q [DLY];
  logic [DLY-1:0]                vld_dly_q, fe_dly_q;
  logic                          vld_al, fe_al;
  logic [NUM_SPRITES-1:0]        opaque, hits_now, hit_mask_d;
  logic [NUM_SPRITES-1:0]        acc_q, hit_mask_q;
  logic [COLOR_W-1:0]            color_d, color_out_q;
  logic                          color_valid_q, hit_any_q;

  assign vld_al = vld_dly_q[DLY-1];
  assign fe_al  = fe_dly_q[DLY-1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_spr
      sprite_hit_test #(
        .PIX_W (PIX_W),
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .ADDR_W(ADDR_W)
      ) u_hit (
        .hor_pix_i(hor_pix),
        .ver_pix_i(ver_pix),
        .x_i      (shadow_x_q[gi*PIX_W +: PIX_W]),
        .y_i      (shadow_y_q[gi*PIX_W +: PIX_W]),
        .en_i     (shadow_en_q[gi]),
        .on_o     (on_d[gi]),
        .addr_o   (addr_d[gi*ADDR_W +: ADDR_W])
      );
      assign opaque[gi] = on_dly_q[DLY-1][gi] &&
                          (rom_data[gi*COLOR_W +: COLOR_W] != KEY_COLOR);
    end
  endgenerate

  // Capture sprite placement on the last pixel so the next frame sees it whole
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_x_q  <= '0;
      shadow_y_q  <= '0;
      shadow_en_q <= '0;
    end else if (pix_en && frame_end) begin
      shadow_x_q  <= spr_x;
      shadow_y_q  <= spr_y;
      shadow_en_q <= spr_en;
    end
  end

  // Register ROM addresses and carry on/valid/frame-end flags toward rom_data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      for (int k = 0; k < DLY; k++) on_dly_q[k] <= '0;
      vld_dly_q  <= '0;
      fe_dly_q   <= '0;
    end else begin
      rom_addr_q  <= addr_d;
      on_dly_q[0] <= on_d & {NUM_SPRITES{pix_en}};
      for (int k = 1; k < DLY; k++) on_dly_q[k] <= on_dly_q[k-1];
      vld_dly_q   <= {vld_dly_q[DLY-2:0], pix_en};
      fe_dly_q    <= {fe_dly_q[DLY-2:0], pix_en & frame_end};
    end
  end

  // Priority mux: lowest-index opaque sprite, then background, then black
  always_comb begin
    color_d = bg_on ? bg_color : '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) color_d = rom_data[i*COLOR_W +: COLOR_W];
    end
  end

  // Collisions of the player car with each other sprite on this pixel
  always_comb begin
    hits_now    = opaque & {NUM_SPRITES{opaque[0]}};
    hits_now[0] = 1'b0;
    hit_mask_d  = acc_q | hits_now;
  end

  // Output pixel register and per-frame collision accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      color_out_q   <= '0;
      color_valid_q <= 1'b0;
      acc_q         <= '0;
      hit_mask_q    <= '0;
      hit_any_q     <= 1'b0;
    end else begin
      color_valid_q <= vld_al;
      if (vld_al) color_out_q <= color_d;
      if (fe_al) begin
        hit_mask_q <= hit_mask_d;
        hit_any_q  <= |hit_mask_d[NUM_SPRITES-1:1];
        acc_q      <= '0;
      end else if (vld_al) begin
        acc_q <= hit_mask_d;
      end
    end
  end

  assign rom_addr    = rom_addr_q;
  assign color_out   = color_out_q;
  assign color_valid = color_valid_q;
  assign hit_mask    = hit_mask_q;
  assign hit_any     = hit_any_q;

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- NUM_SPRITES, 4: sprite layers; index 0 is the player car and has the highest priority.
- SPR_W, 14: sprite width in pixels.
- SPR_H, 16: sprite height in pixels.
- PIX_W, 10: pixel-counter width.
- COLOR_W, 12: RGB444 colour width.
- ADDR_W, 8: sprite ROM address width; must be at least clog2(SPR_W*SPR_H).
- ROM_LAT, 1: sprite ROM read latency in clk cycles, range 1..3.
- KEY_COLOR, 12'hA0A: transparent (pink) key colour.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single system clock; all logic is on its rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- pix_en, in, 1: the current hor_pix/ver_pix sample is a valid pixel.
- hor_pix, in, PIX_W: horizontal pixel counter.
- ver_pix, in, PIX_W: vertical pixel counter.
- frame_end, in, 1: this sample is the last pixel of the frame.
- spr_x, in, NUM_SPRITES*PIX_W: packed sprite left edges.
- spr_y, in, NUM_SPRITES*PIX_W: packed sprite top edges.
- spr_en, in, NUM_SPRITES: per-sprite enable.
- rom_addr, out, NUM_SPRITES*ADDR_W: per-sprite ROM read address.
- rom_data, in, NUM_SPRITES*COLOR_W: per-sprite ROM data, valid ROM_LAT cycles after rom_addr.
- bg_on, in, 1: background pixel present; aligned with rom_data.
- bg_color, in, COLOR_W: background colour; aligned with rom_data.
- color_out, out, COLOR_W: composited pixel colour.
- color_valid, out, 1: color_out carries a valid pixel.
- hit_mask, out, NUM_SPRITES: per-frame pixel-accurate collision, sprite 0 vs sprite i.
- hit_any, out, 1: OR of hit_mask.

Function
REQ-003 The block SHALL sample spr_x, spr_y and spr_en into shadow registers only on a cycle where pix_en=1 and frame_end=1; shadow values govern the whole following frame.
REQ-004 Sprite i SHALL be on for a sample when shadow_en[i]=1, x<=hor_pix<x+SPR_W and y<=ver_pix<y+SPR_H, with the sums computed in PIX_W+1 bits so that nothing wraps.
REQ-005 On the cycle after a sample with pix_en=1, rom_addr[i] SHALL equal (hor_pix-x)+(ver_pix-y)*SPR_W when sprite i is on, and 0 otherwise.
REQ-006 The on flags, pix_en and frame_end SHALL be delayed through a shift register of depth 1+ROM_LAT so that they align with rom_data, bg_on and bg_color.
REQ-007 Sprite i SHALL be opaque when its aligned on flag is 1 and rom_data[i] != KEY_COLOR.
REQ-008 The output mux SHALL select, in priority order, the lowest-index opaque sprite, then bg_color if bg_on=1, otherwise 0.
REQ-009 color_out and color_valid SHALL be registered, giving a latency of exactly ROM_LAT+2 clk cycles from an accepted sample.
REQ-010 color_valid SHALL be 1 only for samples accepted with pix_en=1, and color_out SHALL hold its value while color_valid=0.
REQ-011 For i>=1, the hit accumulator bit i SHALL set whenever sprite 0 and sprite i are opaque in the same aligned pixel.
REQ-012 When the delayed frame_end marker reaches the output stage, hit_mask SHALL load (accumulator OR the current pixel's hits) and the accumulator SHALL clear in the same cycle; hit_mask then holds for one frame.
REQ-013 hit_mask[0] SHALL always be 0, and hit_any SHALL equal the registered OR of hit_mask[NUM_SPRITES-1:1].
REQ-014 A sprite with x+SPR_W beyond the active area SHALL be clipped, not wrapped; a sprite with x>=2**PIX_W-SPR_W SHALL still never match a wrapped hor_pix.
REQ-015 Cycles with pix_en=0 SHALL NOT update the accumulator or the shadow registers.

Reset
REQ-016 While reset_n=0, the following SHALL hold: color_out=0, color_valid=0, rom_addr=0, hit_mask=0, hit_any=0, accumulator=0, all shadow registers=0 (no sprite drawn until the first frame_end), and pipeline valid bits=0.
REQ-017 Reset asserted mid-frame SHALL discard all in-flight pixels, and the first color_valid after release SHALL occur ROM_LAT+2 cycles after the first accepted sample.

Structure
REQ-018 KEY_COLOR, the default widths and the RGB444 field slices SHALL live in the shared package sprite_pkg.
REQ-019 The per-sprite window test and address computation SHALL be a sub-module sprite_hit_test, instantiated NUM_SPRITES times via generate.
REQ-020 The background ROM and its address generation SHALL remain outside this block.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Sprite 0 at (200,150), ROM_LAT=1, sample (203,152) -> rom_addr[0]=31 one cycle later; color_out equals its ROM word 3 cycles later.
- Sprites 0 and 1 both at (300,200), both ROMs opaque -> color_out shows the sprite 0 colour; after frame_end, hit_mask=4'b0010 and hit_any=1.
- Sprite 1 word = 12'hA0A over bg_on=1, bg_color=12'h0F0 -> color_out=12'h0F0; with bg_on=0 -> color_out=0.
- spr_x[0] changed mid-frame from 100 to 120 -> drawing stays at 100 until the sample after frame_end, then moves to 120.
- Sprite 2 at x=630 with 640-wide counters -> columns 630..639 drawn; no pixel appears at hor_pix 0..3.
- reset_n pulsed low mid-frame with ROM_LAT=3 -> all outputs 0 immediately; the first color_valid appears exactly 5 cycles after the first post-reset pix_en.
